// File: rtl/shot_timer_pkg.sv
// ============================================================================
//  Module      : shot_timer_pkg
//  Description : Shared state type and default constants for the shot-clock
//                timer controller and its prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shot_timer_pkg;

   // Controller states; explicit 3-bit encoding keeps the register width fixed
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_PAUSE   = 3'd3,
      ST_EXPIRED = 3'd4
   } state_t;

   // One-second tick at a 50 MHz system clock
   localparam int unsigned C_TICK_DIV_DEF  = 50_000_000;

   // Default shot limit of 30 seconds, two BCD digits {tens,ones}
   localparam logic [7:0]  C_LIMIT_BCD_DEF = 8'h30;

endpackage : shot_timer_pkg

`default_nettype wire

// File: rtl/shot_timer_ctrl_tick_gen.sv
// ============================================================================
//  Module      : tick_gen
//  Description : Prescaler for the shot timer. Counts 0..TICK_DIV-1 while
//                run is high, holds while run is low, clears on clear, and
//                flags the terminal count with a one-cycle tick.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic clk,
   input  logic resetN,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int unsigned      C_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [C_W-1:0]   C_LAST = C_W'(TICK_DIV - 1);

   logic [C_W-1:0] r_cnt;
   logic           w_last;

   assign w_last = (r_cnt == C_LAST);

   // Prescale counter: clear wins, advance only while running, otherwise hold
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (run) begin
         r_cnt <= w_last ? '0 : r_cnt + C_W'(1);
      end
   end

   // Tick only marks a terminal count that is actually being consumed
   assign tick = run && w_last;

endmodule : tick_gen

`default_nettype wire

// File: rtl/shot_timer_ctrl.sv
// ============================================================================
//  Module      : shot_timer_ctrl
//  Description : Shot-clock controller. Sequences two external BCD up
//                counters (ones/tens) through load, run, pause and expiry,
//                generating the per-second count enable from a prescaler.
//                Optional build macro SHOT_TIMER_BLINK_EN makes blink flash
//                with a TICK_DIV period while expired; otherwise blink simply
//                follows expired.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shot_timer_ctrl
   import shot_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV  = C_TICK_DIV_DEF,
   parameter logic [7:0]  LIMIT_BCD = C_LIMIT_BCD_DEF
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       start,
   input  logic       pause,
   input  logic       restart,
   input  logic [3:0] ones,
   input  logic [3:0] tens,
   output logic       loadN,
   output logic       tick_en,
   output logic       running,
   output logic       expired,
   output logic       blink
);

   state_t r_state;
   state_t w_state_nxt;

   logic   w_tick;
   logic   w_at_limit;
   logic   w_pre_clear;
   logic   w_pre_run;

   logic   r_loadN;
   logic   r_tick_en;
   logic   r_running;
   logic   r_expired;

   assign w_at_limit  = ({tens, ones} == LIMIT_BCD);
   assign w_pre_clear = (r_state == ST_LOAD);
   assign w_pre_run   = (r_state == ST_RUN);

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .resetN (resetN),
      .clear  (w_pre_clear),
      .run    (w_pre_run),
      .tick   (w_tick)
   );

   // Next-state decode: restart overrides everything, expiry beats pause in RUN
   always_comb begin
      w_state_nxt = r_state;
      if (restart) begin
         w_state_nxt = ST_LOAD;
      end else begin
         case (r_state)
            ST_IDLE:    if (start)           w_state_nxt = ST_LOAD;
            ST_LOAD:                         w_state_nxt = ST_RUN;
            ST_RUN: begin
               if (w_at_limit)               w_state_nxt = ST_EXPIRED;
               else if (pause)               w_state_nxt = ST_PAUSE;
            end
            ST_PAUSE:   if (start && !pause) w_state_nxt = ST_RUN;
            ST_EXPIRED:                      w_state_nxt = ST_EXPIRED;
            default:                         w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // State register with registered decodes so no output sees an input combinationally
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state   <= ST_IDLE;
         r_loadN   <= 1'b1;
         r_tick_en <= 1'b0;
         r_running <= 1'b0;
         r_expired <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_loadN   <= (w_state_nxt != ST_LOAD);
         r_tick_en <= w_tick && (r_state == ST_RUN) && !w_at_limit;
         r_running <= (w_state_nxt == ST_RUN);
         r_expired <= (w_state_nxt == ST_EXPIRED);
      end
   end

   assign loadN   = r_loadN;
   assign tick_en = r_tick_en;
   assign running = r_running;
   assign expired = r_expired;

`ifdef SHOT_TIMER_BLINK_EN
   localparam int unsigned        C_HALF    = TICK_DIV / 2;
   localparam int unsigned        C_BW      = (C_HALF > 1) ? $clog2(C_HALF) : 1;
   localparam logic [C_BW-1:0]    C_HLAST   = C_BW'(C_HALF - 1);

   logic [C_BW-1:0] r_blink_cnt;
   logic            r_blink;

   // Flash generator: lit on expiry entry, toggles every half tick period, dark otherwise
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b0;
      end else if (w_state_nxt != ST_EXPIRED) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b0;
      end else if (r_state != ST_EXPIRED) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b1;
      end else if (r_blink_cnt == C_HLAST) begin
         r_blink_cnt <= '0;
         r_blink     <= ~r_blink;
      end else begin
         r_blink_cnt <= r_blink_cnt + C_BW'(1);
      end
   end

   assign blink = r_blink;
`else
   assign blink = r_expired;
`endif

endmodule : shot_timer_ctrl

`default_nettype wire

// File: tb/tb_shot_timer_ctrl.sv
// ============================================================================
//  Module      : tb_shot_timer_ctrl
//  Description : Self-checking bench for shot_timer_ctrl with TICK_DIV=4 and
//                LIMIT_BCD=12, driving two BCD up counters from the DUT
//                strobes and comparing against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_shot_timer_ctrl;

   localparam int         TD      = 4;
   localparam logic [7:0] LIM     = 8'h12;
   localparam int         LIM_DEC = 12;

   localparam int M_IDLE  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_RUN   = 2;
   localparam int M_PAUSE = 3;
   localparam int M_EXP   = 4;

   logic       clk     = 1'b0;
   logic       resetN  = 1'b0;
   logic       start   = 1'b0;
   logic       pause   = 1'b0;
   logic       restart = 1'b0;
   logic [3:0] ones;
   logic [3:0] tens;
   logic       loadN;
   logic       tick_en;
   logic       running;
   logic       expired;
   logic       blink;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model: mode, seconds phase, decimal digit value, expiry age
   int m_mode;
   int m_pre;
   int m_digits;
   int m_age;
   bit m_tick_en;
   bit m_loadN;

   always #5 clk = ~clk;

   shot_timer_ctrl #(
      .TICK_DIV  (TD),
      .LIMIT_BCD (LIM)
   ) dut (
      .clk     (clk),
      .resetN  (resetN),
      .start   (start),
      .pause   (pause),
      .restart (restart),
      .ones    (ones),
      .tens    (tens),
      .loadN   (loadN),
      .tick_en (tick_en),
      .running (running),
      .expired (expired),
      .blink   (blink)
   );

   // two cascaded BCD up counters: load to 0, ones enabled by tick_en, tens by ones tc
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         ones <= 4'd0;
         tens <= 4'd0;
      end else if (!loadN) begin
         ones <= 4'd0;
         tens <= 4'd0;
      end else if (tick_en) begin
         if (ones == 4'd9) begin
            ones <= 4'd0;
            tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
         end else begin
            ones <= ones + 4'd1;
         end
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode    = M_IDLE;
      m_pre     = 0;
      m_digits  = 0;
      m_age     = 0;
      m_tick_en = 1'b0;
      m_loadN   = 1'b1;
   endtask

   // advance the model across one clock edge given the inputs of the cycle
   task automatic model_edge(input bit s, input bit p, input bit r);
      int nmode;
      bit at_lim;
      bit sec_done;
      at_lim   = (m_digits == LIM_DEC);
      sec_done = (m_mode == M_RUN) && (m_pre == TD - 1);
      if (!m_loadN)      m_digits = 0;
      else if (m_tick_en) m_digits = (m_digits + 1) % 100;
      nmode = m_mode;
      if (r) nmode = M_LOAD;
      else if (m_mode == M_IDLE && s) nmode = M_LOAD;
      else if (m_mode == M_LOAD) nmode = M_RUN;
      else if (m_mode == M_RUN && at_lim) nmode = M_EXP;
      else if (m_mode == M_RUN && p) nmode = M_PAUSE;
      else if (m_mode == M_PAUSE && s && !p) nmode = M_RUN;
      if (m_mode == M_LOAD)     m_pre = 0;
      else if (m_mode == M_RUN) m_pre = (m_pre + 1) % TD;
      m_tick_en = sec_done && !at_lim;
      m_age     = (nmode == M_EXP && m_mode == M_EXP) ? m_age + 1 : 0;
      m_loadN   = (nmode != M_LOAD);
      m_mode    = nmode;
   endtask

   task automatic check_all();
      int exp_blink;
`ifdef SHOT_TIMER_BLINK_EN
      exp_blink = (m_mode == M_EXP && ((m_age / (TD / 2)) % 2) == 0) ? 1 : 0;
`else
      exp_blink = (m_mode == M_EXP) ? 1 : 0;
`endif
      chk("loadN",   int'(loadN),   int'(m_loadN));
      chk("tick_en", int'(tick_en), int'(m_tick_en));
      chk("running", int'(running), (m_mode == M_RUN) ? 1 : 0);
      chk("expired", int'(expired), (m_mode == M_EXP) ? 1 : 0);
      chk("blink",   int'(blink),   exp_blink);
      chk("digits",  int'(tens) * 10 + int'(ones), m_digits);
   endtask

   task automatic step(input bit s, input bit p, input bit r);
      start   = s;
      pause   = p;
      restart = r;
      @(posedge clk);
      model_edge(s, p, r);
      @(negedge clk);
      start   = 1'b0;
      pause   = 1'b0;
      restart = 1'b0;
      check_all();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_loadN"},   int'(loadN),   1);
      chk({tag, "_tick_en"}, int'(tick_en), 0);
      chk({tag, "_running"}, int'(running), 0);
      chk({tag, "_expired"}, int'(expired), 0);
      chk({tag, "_blink"},   int'(blink),   0);
   endtask

   initial begin
      int lat;
      int pulses;
      int extra;
      int toggles;
      int budget;
      logic       prev_blink;
      logic [7:0] held;

      model_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      resetN = 1'b1;
      step(0, 0, 0);

      // start from IDLE: one load cycle, then RUN, first enable TD cycles later
      step(1, 0, 0);
      chk("load_strobe", int'(loadN), 0);
      step(0, 0, 0);
      chk("run_after_load", int'(running), 1);
      chk("load_released", int'(loadN), 1);
      lat = 0;
      while (!tick_en && lat < 20) begin
         step(0, 0, 0);
         lat++;
      end
      chk("first_tick_latency", lat, TD);

      // free run to the limit
      pulses = 1;
      budget = 0;
      while (!expired && budget < 200) begin
         step(0, 0, 0);
         if (tick_en) pulses++;
         budget++;
      end
      chk("pulses_to_limit", pulses, LIM_DEC);
      chk("digits_at_limit", int'({tens, ones}), int'(LIM));
      chk("expired_at_limit", int'(expired), 1);
      chk("running_at_limit", int'(running), 0);
      chk("blink_on_entry", int'(blink), 1);

      // stay expired: no enables, start/pause ignored, blink cadence
      extra   = 0;
      toggles = 0;
      prev_blink = blink;
      for (int i = 0; i < 8; i++) begin
         step(i == 2, i == 5, 0);
         if (tick_en) extra++;
         if (blink != prev_blink) toggles++;
         prev_blink = blink;
      end
      chk("no_tick_after_expiry", extra, 0);
      chk("still_expired", int'(expired), 1);
`ifdef SHOT_TIMER_BLINK_EN
      chk("blink_toggles", toggles, 4);
`else
      chk("blink_toggles", toggles, 0);
`endif

      // restart out of EXPIRED
      step(0, 0, 1);
      chk("restart_exp_load", int'(loadN), 0);
      step(0, 0, 0);
      chk("restart_exp_run", int'(running), 1);
      chk("restart_exp_digits", int'({tens, ones}), 0);

      // pause with prescaler at 2, hold 10 cycles, resume
      step(0, 0, 0);
      step(0, 1, 0);
      chk("paused", int'(running), 0);
      held = {tens, ones};
      repeat (5) step(0, 0, 0);
      step(1, 1, 0);
      repeat (4) step(0, 0, 0);
      chk("pause_hold_digits", int'({tens, ones}), int'(held));
      chk("pause_hold_state", int'(running), 0);
      step(1, 0, 0);
      chk("resume_running", int'(running), 1);
      lat = 0;
      while (!tick_en && lat < 20) begin
         step(0, 0, 0);
         lat++;
      end
      chk("resume_tick_latency", lat, 2);

      // restart together with pause in RUN
      step(0, 1, 1);
      chk("restart_pause_load", int'(loadN), 0);
      step(0, 0, 0);
      chk("restart_pause_run", int'(running), 1);
      chk("restart_pause_digits", int'({tens, ones}), 0);

      // asynchronous reset mid-RUN at digits 07
      budget = 0;
      while ({tens, ones} != 8'h07 && budget < 100) begin
         step(0, 0, 0);
         budget++;
      end
      chk("reach_07", int'({tens, ones}), 7);
      step(0, 0, 0);
      resetN = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      model_reset();
      @(negedge clk);
      resetN = 1'b1;
      check_all();
      step(0, 1, 0);
      step(1, 0, 0);
      chk("idle_after_reset", int'(loadN), 0);

      // randomized traffic against the model, with occasional async resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            resetN = 1'b0;
            #2;
            model_reset();
            check_all();
            @(negedge clk);
            resetN = 1'b1;
         end else begin
            step($urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 149) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_shot_timer_ctrl

`default_nettype wire

// File: doc/shot_timer_ctrl.md
SHOT_TIMER_CTRL -- requirements
Module: shot_timer_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, clk cycles per one-second tick (minimum 4).
REQ-002 SHALL have parameter LIMIT_BCD, default 8'h30, two-digit BCD limit {tens,ones}; each nibble 0-9.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port resetN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle pulse, begin or resume timing.
REQ-006 SHALL have port pause  input  1  single-cycle pulse, freeze timing.
REQ-007 SHALL have port restart  input  1  single-cycle pulse, clear digits and re-arm.
REQ-008 SHALL have port ones  input  4  BCD count read back from the ones-digit up counter.
REQ-009 SHALL have port tens  input  4  BCD count read back from the tens-digit up counter.
REQ-010 SHALL have port loadN  output  1  active-low load strobe to both digit counters; their datain is tied to 4'h0.
REQ-011 SHALL have port tick_en  output  1  one-cycle count enable to the ones digit; the ones-digit tc gates the tens digit.
REQ-012 SHALL have port running  output  1  high in RUN.
REQ-013 SHALL have port expired  output  1  high in EXPIRED.
REQ-014 SHALL have port blink  output  1  display-flash control.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, PAUSE, EXPIRED.
REQ-016 SHALL treat restart as highest priority: any state -> LOAD on the next edge.
REQ-017 SHALL transition IDLE -> LOAD on start; LOAD -> RUN unconditionally after exactly one cycle.
REQ-018 SHALL transition RUN -> PAUSE on pause; pause wins over a simultaneous start.
REQ-019 SHALL transition PAUSE -> RUN on start when pause is not also asserted.
REQ-020 SHALL transition RUN -> EXPIRED on the edge where {tens,ones} == LIMIT_BCD.
REQ-021 SHALL leave EXPIRED only on restart; start and pause are ignored there.
REQ-022 SHALL drive loadN low for exactly the single cycle in LOAD and high otherwise.
REQ-023 SHALL run a prescaler counting 0..TICK_DIV-1 that wraps to 0 and pulses tick for one cycle at TICK_DIV-1.
REQ-024 SHALL clear the prescaler in LOAD, advance it only in RUN, and hold its value in PAUSE.
REQ-025 SHALL drive tick_en = tick AND state==RUN AND {tens,ones} != LIMIT_BCD, so the digits never pass the limit.
REQ-026 SHALL make running and expired registered state decodes with no combinational input path.
REQ-027 SHALL give the first tick_en after LOAD exactly TICK_DIV cycles after entry to RUN.

Reset
REQ-028 SHALL force state IDLE, prescaler 0, blink 0, loadN 1, tick_en 0, running 0 and expired 0 while resetN is low.
REQ-029 SHALL apply reset immediately when asserted mid-RUN, discarding any pending tick.
REQ-030 SHALL leave the digit counters to their own reset; this block issues no loadN on reset exit.

Configuration
REQ-031 SHALL, with macro SHOT_TIMER_BLINK_EN defined, toggle blink every TICK_DIV/2 cycles while in EXPIRED, starting from 1 on entry.
REQ-032 SHALL clear blink to 0 when leaving EXPIRED.
REQ-033 SHALL, without SHOT_TIMER_BLINK_EN, drive blink equal to expired, with no blink counter synthesized.

Structure
REQ-034 SHALL take the state enum type and default TICK_DIV / LIMIT_BCD constants from package shot_timer_pkg.
REQ-035 SHALL place the prescaler in sub-module tick_gen, with ports clk, resetN, clear, run and tick.

Verification (TICK_DIV=4, LIMIT_BCD=8'h12, bench instantiates two up_counters)
REQ-036 SHALL check: start in IDLE -> loadN low for 1 cycle, running high next cycle, first tick_en 4 cycles later.
REQ-037 SHALL check: free run from 00 -> digits reach 12 after 12 tick_en pulses, then expired=1, running=0, and no further tick_en.
REQ-038 SHALL check: pause at prescaler value 2, hold 10 cycles, then start -> next tick_en 2 cycles after resume and digits unchanged while paused.
REQ-039 SHALL check: restart in EXPIRED, and restart together with pause in RUN -> LOAD then RUN, digits 00.
REQ-040 SHALL check: resetN low mid-RUN at digits 07 -> all outputs at reset values within the same cycle, and state IDLE after release.
REQ-041 SHALL check: with SHOT_TIMER_BLINK_EN, EXPIRED -> blink period 4 cycles; without the macro, blink equals expired.
